// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared LCD pixel-depth definitions used by the pixel packer and by the
// per-depth pixel-select decoders on the read side.
//   bpp_e      : encoded pixel depth (1/2/4/8/16 bits per pixel)
//   bpp_norm   : maps the raw 3-bit depth select onto bpp_e (5..7 -> 16bpp)
//   bpp_width  : bits per pixel for a depth
//   bpp_ppw    : pixels per 32-bit frame-buffer word for a depth
// -----------------------------------------------------------------------------
package lcd_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        BPP1  = 3'd0,
        BPP2  = 3'd1,
        BPP4  = 3'd2,
        BPP8  = 3'd3,
        BPP16 = 3'd4
    } bpp_e;

    // Codes above 16bpp are reserved and fall back to the widest depth.
    function automatic bpp_e bpp_norm(input logic [2:0] code);
        return (code > 3'd4) ? BPP16 : bpp_e'(code);
    endfunction

    function automatic logic [4:0] bpp_width(input bpp_e bpp);
        logic [4:0] w;
        case (bpp)
            BPP1:    w = 5'd1;
            BPP2:    w = 5'd2;
            BPP4:    w = 5'd4;
            BPP8:    w = 5'd8;
            default: w = 5'd16;
        endcase
        return w;
    endfunction

    function automatic logic [5:0] bpp_ppw(input bpp_e bpp);
        logic [5:0] n;
        case (bpp)
            BPP1:    n = 6'd32;
            BPP2:    n = 6'd16;
            BPP4:    n = 6'd8;
            BPP8:    n = 6'd4;
            default: n = 6'd2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pixel_packer_if.sv
// -----------------------------------------------------------------------------
// pixel_packer_if
// Generic valid/ready stream with an end-of-line marker. Used twice by the
// packer: once for the incoming pixel stream (DATA_W = 16) and once for the
// outgoing frame-buffer word stream (DATA_W = 32).
//   valid : source has a beat
//   ready : sink accepts the beat this cycle
//   data  : beat payload
//   last  : beat closes a line
// -----------------------------------------------------------------------------
interface pixel_packer_if #(
    parameter int DATA_W = 32
);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input  ready);
    modport slave  (input  valid, input  data, input  last, output ready);

endinterface

// File: rtl/pixel_insert.sv
// -----------------------------------------------------------------------------
// pixel_insert
// Combinational placement of one pixel into a partially built 32-bit word.
// Pixel k of a word lives at bits [k*bpp +: bpp], the same position the
// read-side pixel-select decoders extract it from.
//   acc_i      : word built so far (unused slots are zero)
//   pix_i      : pixel value, only the low bpp bits are significant
//   idx_i      : slot index of this pixel within the word
//   bpp_i      : pixel depth
//   acc_next_o : acc_i with the masked pixel ORed into its slot
// -----------------------------------------------------------------------------
module pixel_insert
    import lcd_pkg::*;
(
    input  logic [WORD_W-1:0] acc_i,
    input  logic [15:0]       pix_i,
    input  logic [4:0]        idx_i,
    input  bpp_e              bpp_i,
    output logic [WORD_W-1:0] acc_next_o
);

    logic [WORD_W-1:0] field;
    logic [4:0]        shamt;

    // Selecting the low bpp bits by width is the mask; the slot offset is
    // idx*bpp, which for power-of-two depths is just idx shifted left.
    // NOTE: every signal driven in always_comb gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        field = '0;
        shamt = '0;
        case (bpp_i)
            BPP1: begin
                field = {{(WORD_W-1){1'b0}}, pix_i[0]};
                shamt = idx_i;
            end
            BPP2: begin
                field = {{(WORD_W-2){1'b0}}, pix_i[1:0]};
                shamt = {idx_i[3:0], 1'b0};
            end
            BPP4: begin
                field = {{(WORD_W-4){1'b0}}, pix_i[3:0]};
                shamt = {idx_i[2:0], 2'b0};
            end
            BPP8: begin
                field = {{(WORD_W-8){1'b0}}, pix_i[7:0]};
                shamt = {idx_i[1:0], 3'b0};
            end
            default: begin
                field = {{(WORD_W-16){1'b0}}, pix_i};
                shamt = {idx_i[0], 4'b0};
            end
        endcase
    end

    assign acc_next_o = acc_i | (field << shamt);

endmodule

// File: rtl/pixel_packer.sv
// -----------------------------------------------------------------------------
// pixel_packer
// Packs LCD pixels of 1/2/4/8/16 bpp into 32-bit frame-buffer words. Sits
// between the pixel source and the frame-buffer write port. A word is emitted
// when all its slots are filled or when a pixel carries the end-of-line flag;
// unused upper slots of such a partial word are zero.
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active low
//   en      : 0 stalls pixel intake; a pending output word still drains
//   bpp_sel : depth select, 0=1 1=2 2=4 3=8 4..7=16 bpp
//   pix     : pixel stream (slave): valid/ready/data[PIX_W]/last
//   word    : packed word stream (master): valid/ready/data[WORD_W]/last
// Depth is latched on the first pixel of each word and held until the word
// closes. The output word register is the only output buffer, so intake is
// stalled whenever it is full and not being drained.
// -----------------------------------------------------------------------------
module pixel_packer #(
    parameter int WORD_W = 32,
    parameter int PIX_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [2:0]            bpp_sel,
    pixel_packer_if.slave         pix,
    pixel_packer_if.master        word
);

    import lcd_pkg::*;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic              run_q;          // low only until the first edge after reset
    bpp_e              cur_bpp_q,   cur_bpp_d;
    logic [4:0]        idx_q,       idx_d;
    logic [WORD_W-1:0] acc_q,       acc_d;
    logic [WORD_W-1:0] word_data_q, word_data_d;
    logic              word_valid_q, word_valid_d;
    logic              word_last_q,  word_last_d;

    // ------------------------------------------------------------------------
    // Intake control
    // ------------------------------------------------------------------------
    logic              pix_ready;
    logic              accept;
    logic              complete;
    logic              word_hs;
    bpp_e              eff_bpp;
    logic [PIX_W-1:0]  pix_data;
    logic [WORD_W-1:0] acc_ins;

    assign pix_data = pix.data;

    // Ready depends only on registered state, en and the sink's ready, never
    // on pix.valid, so source and packer cannot form a combinational loop.
    assign pix_ready = run_q && en && (!word_valid_q || word.ready);
    assign accept    = pix.valid && pix_ready;
    assign word_hs   = word_valid_q && word.ready;

    // The first pixel of a word uses the live select; later pixels use the
    // depth latched when that first pixel was taken.
    assign eff_bpp  = (idx_q == 5'd0) ? bpp_norm(bpp_sel) : cur_bpp_q;

    assign complete = accept &&
                      (({1'b0, idx_q} == (bpp_ppw(eff_bpp) - 6'd1)) || pix.last);

    pixel_insert u_insert (
        .acc_i      (acc_q),
        .pix_i      (pix_data),
        .idx_i      (idx_q),
        .bpp_i      (eff_bpp),
        .acc_next_o (acc_ins)
    );

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        cur_bpp_d    = cur_bpp_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q;
        word_last_d  = word_last_q;

        if (word_hs) begin
            word_valid_d = 1'b0;
        end

        if (accept) begin
            if (idx_q == 5'd0) begin
                cur_bpp_d = eff_bpp;
            end
            if (complete) begin
                // Loading here overrides the drop above, so a word handshake
                // on the same edge leaves word_valid high with the new word.
                word_data_d  = acc_ins;
                word_valid_d = 1'b1;
                word_last_d  = pix.last;
                acc_d        = '0;
                idx_d        = 5'd0;
            end else begin
                acc_d = acc_ins;
                idx_d = idx_q + 5'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // The accumulator is reset too: a word interrupted by reset is dropped
    // and the next word must start from an all-zero slot map.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q        <= 1'b0;
            cur_bpp_q    <= BPP1;
            idx_q        <= 5'd0;
            acc_q        <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
        end else begin
            run_q        <= 1'b1;
            cur_bpp_q    <= cur_bpp_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            word_last_q  <= word_last_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pix.ready  = pix_ready;
    assign word.valid = word_valid_q;
    assign word.data  = word_data_q;
    assign word.last  = word_last_q;

endmodule

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
- Packs a stream of LCD pixels of selectable depth (1/2/4/8/16 bpp) into 32-bit frame-buffer words.
- It is the write-side counterpart of the per-depth pixel-select decoders: pixel k of a word occupies bits [k*bpp +: bpp], the same placement those decoders extract.
- Sits between the pixel source (pattern/DMA-in path) and the frame-buffer write port.
- Valid/ready handshake on both sides; partial words are flushed on end of line.

Parameters:
- WORD_W, 32, output word width; only 32 is supported.
- PIX_W, 16, input pixel bus width; equals the maximum bpp.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  packer enable; 0 blocks new pixels, output handshake still completes.
- bpp_sel  input  3  0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp, 4=16bpp, 5..7 treated as 16bpp.
- pix_valid  input  1  pixel present.
- pix_ready  output  1  packer accepts pixel this cycle.
- pix_data  input  PIX_W  pixel value, low bpp bits used.
- pix_last  input  1  last pixel of line; forces word emission.
- word_valid  output  1  packed word present.
- word_ready  input  1  sink accepts word.
- word_data  output  WORD_W  packed word.
- word_last  output  1  word closes a line (emitted because of pix_last).

Behaviour:
- Reset (rst=0, asynchronous): word_valid=0, word_data=0, word_last=0, pix_ready=0. Accumulator, index and latched bpp are cleared. A partial word is discarded, not emitted.
- pix_ready = en && (!word_valid || word_ready). Registered state only; no combinational path from pix_valid.
- A pixel is accepted when pix_valid && pix_ready.
- Latched depth cur_bpp:
  - Sampled from bpp_sel on the accept that hits idx=0, i.e. the first pixel of each word.
  - Held for the rest of the word; bpp_sel changes mid-word are ignored until the next word.
  - The first pixel itself uses the bpp_sel value present on that cycle.
- Pixels per word: ppw = 32/bpp, giving 32, 16, 8, 4 or 2.
- On accept:
  - Masked pixel (pix_data & ((1<<bpp)-1)) is ORed into acc at bits [idx*bpp +: bpp].
  - If idx==ppw-1 or pix_last: on the next edge word_data = acc | placed pixel, word_valid=1, word_last=pix_last; acc, idx and word-start are cleared.
  - Otherwise idx increments.
- Padding: unused upper pixel slots of a flushed partial word are 0.
- Latency: one cycle from the accepting edge of the completing pixel to word_valid=1.
- Throughput: one pixel per cycle with word_ready held high, i.e. one word every ppw cycles and no bubbles.
- Output register:
  - word_data and word_last stay stable while word_valid && !word_ready.
  - word_valid drops the cycle after a handshake unless a new word is loaded on the same edge.
  - A simultaneous word handshake and completing-pixel accept loads the new word with word_valid staying 1.
- Backpressure: while word_valid && !word_ready, pix_ready=0. No pixel is lost or duplicated.
- en=0 mid-word: acc and idx are held; accumulation resumes when en returns to 1.
- pix_last on pixel 0 of a word gives a word with a single pixel and word_last=1.
- pix_last on slot ppw-1 gives one word with word_last=1, not an extra empty word.

Decomposition:
- Shared package lcd_pkg:
  - enum bpp_e: BPP1=0, BPP2=1, BPP4=2, BPP8=3, BPP16=4.
  - Functions bpp_width(bpp_e) returning 1..16 and bpp_ppw(bpp_e) returning 32..2.
  - Function bpp_norm mapping codes 5..7 to BPP16.
  - Localparam WORD_W=32.
- One combinational sub-module, pixel_insert(acc, pix, idx, bpp) -> acc_next, containing the mask, shift and OR.
- FSM-free control lives in pixel_packer: idx counter, cur_bpp register, output register.

Test Plan:
- 1bpp, 32 pixels alternating 1,0 starting with 1, word_ready=1 -> one word 0x55555555, word_last=0; pix_ready high throughout.
- 8bpp, pixels 0x11,0x22,0x33,0x44 -> word 0x44332211; word_valid asserted exactly 1 cycle after the 4th accept.
- 16bpp, 0xABCD with pix_last=1 -> word 0x0000ABCD, word_last=1. 4bpp, 3 pixels 0xF,0x1,0x2 with pix_last on the 3rd -> 0x0000021F, word_last=1.
- Backpressure: 8bpp, word_ready=0 for 3 cycles after word 0x04030201 forms -> word_data stable, pix_ready=0, next pixel 0x05 not accepted until word_ready=1; the following word starts with 0x05.
- Masking and bpp latch:
  - 2bpp, every pixel = 0xFFFF -> word 0xFFFFFFFF.
  - Start 4bpp, switch bpp_sel to 2bpp after pixel 3 -> word still packs 8 nibbles; the next word is 2bpp.
- Reset mid-word: 8bpp, 2 pixels accepted, rst low 1 cycle -> no word emitted, all outputs 0. After release, 0xAA,0xBB,0xCC,0xDD -> 0xDDCCBBAA.
